// File: rtl/clk_step_pkg.sv
// Shared encodings for the microcycle run/halt/single-step sequencer.
package clk_step_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  localparam logic [1:0] CC_RUN  = 2'b00;
  localparam logic [1:0] CC_HALT = 2'b01;
  localparam logic [1:0] CC_STEP = 2'b10;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  // SAC control field presented while in a given state.
  function automatic logic [1:0] cc_of(input state_t s);
    logic [1:0] cc;
    case (s)
      ST_RUNNING:  cc = CC_RUN;
      ST_STEPPING: cc = CC_STEP;
      ST_HALTED:   cc = CC_HALT;
      ST_STOPPING: cc = CC_HALT;
      default:     cc = CC_HALT;
    endcase
    return cc;
  endfunction

endpackage

// File: rtl/clk_step_ctl_if.sv
// Console command handshake between the console/diagnostic master and the sequencer.
interface clk_step_ctl_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid_h;
  logic             cmd_ready_h;
  logic [1:0]       cmd_op_h;
  logic [CNT_W-1:0] cmd_count_h;

  modport master (
    output cmd_valid_h, cmd_op_h, cmd_count_h,
    input  cmd_ready_h
  );

  modport slave (
    input  cmd_valid_h, cmd_op_h, cmd_count_h,
    output cmd_ready_h
  );
endinterface

// File: rtl/ucyc_counter.sv
// Loadable down-counter with zero/one detect; load has priority over decrement.
module ucyc_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero,
  output logic         o_one
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Count register; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
  assign o_one  = (r_cnt == ONE);
endmodule

// File: rtl/clk_step_ctl.sv
// Run/halt/single-step sequencer driving the SAC clock control field,
// with sticky break/timeout status and a console command handshake.
module clk_step_ctl
  import clk_step_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STOP_TMO = 16
) (
  input  logic             base_clock_h,
  input  logic             mseq_init_l,
  clk_step_ctl_if.slave    cmd_if,
  input  logic             m_clk_enable_h,
  input  logic             con_halt_req_h,
  output logic [1:0]       clk_ctrl_h,
  output logic             halted_h,
  output logic             step_done_h,
  output logic [CNT_W:0]   steps_left_h,
  output logic             brk_h,
  output logic             tmo_h,
  output logic             cmd_err_h
);
  localparam int TMO_W = $clog2(STOP_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(STOP_TMO);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_clk_ctrl;
  logic             r_step_done, r_cmd_err, r_brk, r_tmo;
  logic             w_step_done_nxt, w_cmd_err_nxt, w_brk_nxt, w_tmo_nxt;
  logic             w_accept;
  logic             w_step_load, w_step_dec, w_step_zero, w_step_one;
  logic [CNT_W:0]   w_step_load_val;
  logic             w_tmo_load, w_tmo_dec, w_tmo_zero, w_tmo_one;
  logic [TMO_W-1:0] w_tmo_cnt;

  assign cmd_if.cmd_ready_h = ((r_state == ST_HALTED) || (r_state == ST_RUNNING))
                              && !con_halt_req_h;
  assign w_accept = cmd_if.cmd_valid_h && cmd_if.cmd_ready_h;

  // A zero count selects the full 2^CNT_W range.
  assign w_step_load_val = (cmd_if.cmd_count_h == '0) ? {1'b1, {CNT_W{1'b0}}}
                                                      : {1'b0, cmd_if.cmd_count_h};

  ucyc_counter #(.W(CNT_W + 1)) u_step_cnt (
    .clk        (base_clock_h),
    .rst_n      (mseq_init_l),
    .i_load     (w_step_load),
    .i_load_val (w_step_load_val),
    .i_dec      (w_step_dec),
    .o_cnt      (steps_left_h),
    .o_zero     (w_step_zero),
    .o_one      (w_step_one)
  );

  ucyc_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk        (base_clock_h),
    .rst_n      (mseq_init_l),
    .i_load     (w_tmo_load),
    .i_load_val (TMO_LOAD),
    .i_dec      (w_tmo_dec),
    .o_cnt      (w_tmo_cnt),
    .o_zero     (w_tmo_zero),
    .o_one      (w_tmo_one)
  );

  // Next-state, counter controls and next values of the registered status outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_brk_nxt       = r_brk;
    w_tmo_nxt       = r_tmo;
    w_step_done_nxt = 1'b0;
    w_cmd_err_nxt   = 1'b0;
    w_step_load     = 1'b0;
    w_step_dec      = 1'b0;
    w_tmo_load      = 1'b0;
    w_tmo_dec       = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (w_accept) begin
          case (cmd_if.cmd_op_h)
            OP_RUN: begin
              w_state_nxt = ST_RUNNING;
              w_brk_nxt   = 1'b0;
              w_tmo_nxt   = 1'b0;
            end
            OP_STEP: begin
              w_state_nxt = ST_STEPPING;
              w_step_load = 1'b1;
              w_brk_nxt   = 1'b0;
              w_tmo_nxt   = 1'b0;
            end
            default: w_state_nxt = ST_HALTED;
          endcase
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        if (con_halt_req_h) begin
          w_state_nxt = ST_STOPPING;
          w_brk_nxt   = 1'b1;
          w_tmo_load  = 1'b1;
        end else if (w_accept) begin
          case (cmd_if.cmd_op_h)
            OP_HALT: begin
              w_state_nxt = ST_STOPPING;
              w_tmo_load  = 1'b1;
            end
            OP_STEP: w_cmd_err_nxt = 1'b1;
            default: w_state_nxt = ST_RUNNING;
          endcase
        end else begin
          w_state_nxt = ST_RUNNING;
        end
      end
      ST_STEPPING: begin
        // A break abandons the step with the remaining count frozen.
        if (con_halt_req_h) begin
          w_state_nxt = ST_STOPPING;
          w_brk_nxt   = 1'b1;
          w_tmo_load  = 1'b1;
        end else if (m_clk_enable_h) begin
          w_step_dec = 1'b1;
          if (w_step_one || w_step_zero) begin
            w_state_nxt     = ST_HALTED;
            w_step_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_STEPPING;
          end
        end else begin
          w_state_nxt = ST_STEPPING;
        end
      end
      ST_STOPPING: begin
        if (m_clk_enable_h) begin
          w_state_nxt = ST_HALTED;
        end else if (w_tmo_one || w_tmo_zero) begin
          w_state_nxt = ST_HALTED;
          w_tmo_nxt   = 1'b1;
          w_tmo_dec   = 1'b1;
        end else begin
          w_tmo_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_HALTED;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge base_clock_h or negedge mseq_init_l) begin
    if (!mseq_init_l) begin
      r_state     <= ST_HALTED;
      r_clk_ctrl  <= CC_HALT;
      r_step_done <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_brk       <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_ctrl  <= cc_of(w_state_nxt);
      r_step_done <= w_step_done_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_brk       <= w_brk_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  assign clk_ctrl_h  = r_clk_ctrl;
  assign halted_h    = (r_state == ST_HALTED);
  assign step_done_h = r_step_done;
  assign cmd_err_h   = r_cmd_err;
  assign brk_h       = r_brk;
  assign tmo_h       = r_tmo;
endmodule
